// File: rtl/multi_ch_logger.sv
// multi_ch_logger: multi-channel capture logger with one-shot / circular-trigger modes and oldest-first readback
//   clock        rising-edge clock
//   i_reset      asynchronous active-high reset
//   i_data       N_CH channels of DATA_W bits, channel k at [k*DATA_W +: DATA_W]
//   i_start      capture start pulse (accepted in IDLE/DONE), latches i_mode and i_decim
//   i_abort      return to IDLE, flush readback
//   i_mode       0 = one-shot fill, 1 = circular with trigger
//   i_trigger    trigger level, used in ARMED mode 1 only
//   i_post_count post-trigger write count, latched on trigger
//   i_decim      one write every i_decim+1 cycles
//   i_rd_en      readback request (DONE only), i_rd_addr = logical index, 0 = oldest
//   o_rd_data    readback word, valid two cycles after request with o_rd_valid
//   o_state      IDLE=0 ARMED=1 POST=2 DONE=3; o_mem_full high in DONE
//   o_trig_addr  write pointer at trigger; o_wr_addr current write pointer
module multi_ch_logger #(
   parameter int N_CH   = 2,
   parameter int DATA_W = 11,
   parameter int N_ADDR = 10
) (
   input  logic                     clock,
   input  logic                     i_reset,
   input  logic [N_CH*DATA_W-1:0]   i_data,
   input  logic                     i_start,
   input  logic                     i_abort,
   input  logic                     i_mode,
   input  logic                     i_trigger,
   input  logic [N_ADDR-1:0]        i_post_count,
   input  logic [7:0]               i_decim,
   input  logic                     i_rd_en,
   input  logic [N_ADDR-1:0]        i_rd_addr,
   output logic [N_CH*DATA_W-1:0]   o_rd_data,
   output logic                     o_rd_valid,
   output logic [1:0]               o_state,
   output logic                     o_mem_full,
   output logic [N_ADDR-1:0]        o_trig_addr,
   output logic [N_ADDR-1:0]        o_wr_addr
);
   localparam int W = N_CH*DATA_W;
   localparam logic [1:0] S_IDLE = 2'd0, S_ARMED = 2'd1, S_POST = 2'd2, S_DONE = 2'd3;
   localparam logic [N_ADDR-1:0] A_MAX = '1;
   logic [1:0]        r_state, w_next;
   logic [N_ADDR-1:0] r_wr_addr, r_trig_addr, r_post_cnt, w_oldest, w_addr;
   logic [7:0]        r_dec_cnt, r_decim;
   logic              r_mode, r_wrapped, r_rd_v1, r_rd_valid;
   logic [W-1:0]      r_ram_q, r_rd_data;
   logic [W-1:0]      r_mem [0:(1<<N_ADDR)-1];
   logic              w_run, w_we, w_start, w_trig, w_rd;
   always_ff @(posedge clock or posedge i_reset)
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next;
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: if (w_start) w_next = S_ARMED;
         S_ARMED:
            if (!r_mode && w_we && r_wr_addr == A_MAX) w_next = S_DONE;
            else if (w_trig) w_next = (i_post_count == '0) ? S_DONE : S_POST;
         S_POST: if (w_we && r_post_cnt == N_ADDR'(1)) w_next = S_DONE;
      endcase
      if (i_abort) w_next = S_IDLE;
   end
   always_comb begin
      w_run      = (r_state == S_ARMED) || (r_state == S_POST);
      w_we       = w_run && (r_dec_cnt == 8'd0) && !i_abort && !i_reset;
      w_start    = i_start && !w_run && !i_abort;
      w_trig     = (r_state == S_ARMED) && r_mode && i_trigger && !i_abort;
      w_rd       = i_rd_en && (r_state == S_DONE) && !i_abort;
      o_mem_full = r_state == S_DONE;
   end
   // Only a wrapped circular capture has its oldest sample away from address 0.
   assign w_oldest    = (r_mode && r_wrapped) ? r_wr_addr : '0;
   // Writes happen only while capturing and reads only in DONE, so one port suffices.
   assign w_addr      = w_we ? r_wr_addr : w_oldest + i_rd_addr;
   assign o_state     = r_state;
   assign o_wr_addr   = r_wr_addr;
   assign o_trig_addr = r_trig_addr;
   assign o_rd_data   = r_rd_data;
   assign o_rd_valid  = r_rd_valid;
   always_ff @(posedge clock) begin
      if (w_we) r_mem[w_addr] <= i_data;
      r_ram_q <= r_mem[w_addr];
   end
   always_ff @(posedge clock or posedge i_reset)
      if (i_reset) begin
         r_wr_addr   <= '0;
         r_trig_addr <= '0;
         r_post_cnt  <= '0;
         r_dec_cnt   <= '0;
         r_decim     <= '0;
         r_mode      <= 1'b0;
         r_wrapped   <= 1'b0;
         r_rd_v1     <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_rd_data   <= '0;
      end else begin
         if (w_start) begin
            r_wr_addr <= '0;
            r_dec_cnt <= '0;
            r_wrapped <= 1'b0;
            r_mode    <= i_mode;
            r_decim   <= i_decim;
         end else if (w_we) begin
            r_wr_addr <= r_wr_addr + 1'b1;
            r_dec_cnt <= r_decim;
            if (r_wr_addr == A_MAX) r_wrapped <= 1'b1;
         end else if (w_run) r_dec_cnt <= r_dec_cnt - 1'b1;
         if (w_trig) begin
            r_trig_addr <= r_wr_addr;
            r_post_cnt  <= i_post_count;
         end else if (w_we && r_state == S_POST) r_post_cnt <= r_post_cnt - 1'b1;
         r_rd_v1    <= w_rd;
         r_rd_valid <= r_rd_v1 && !i_abort;
         if (r_rd_v1 && !i_abort) r_rd_data <= r_ram_q;
      end
endmodule

// File: tb/tb_multi_ch_logger.sv
// tb_multi_ch_logger: directed table-driven bench for multi_ch_logger at N_ADDR=4
module tb_multi_ch_logger;
   logic        clock, i_reset, i_start, i_abort, i_mode, i_trigger, i_rd_en;
   logic [21:0] i_data, o_rd_data;
   logic [3:0]  i_post_count, i_rd_addr, o_trig_addr, o_wr_addr;
   logic [7:0]  i_decim;
   logic        o_rd_valid, o_mem_full;
   logic [1:0]  o_state;
   int          n_cmp = 0, n_bad = 0;
   multi_ch_logger #(.N_CH(2), .DATA_W(11), .N_ADDR(4)) dut (
      .clock(clock), .i_reset(i_reset), .i_data(i_data), .i_start(i_start),
      .i_abort(i_abort), .i_mode(i_mode), .i_trigger(i_trigger),
      .i_post_count(i_post_count), .i_decim(i_decim), .i_rd_en(i_rd_en),
      .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
      .o_state(o_state), .o_mem_full(o_mem_full), .o_trig_addr(o_trig_addr),
      .o_wr_addr(o_wr_addr)
   );
   initial clock = 1'b0;
   always #5 clock = ~clock;
   typedef struct {
      logic       mode;
      int         trig_n;
      logic [3:0] post;
      logic [3:0] rd;
      int         exp_s;
      int         exp_last;
      int         exp_trig;
   } vec_t;
   vec_t tbl[9];
   function automatic logic [21:0] smp(input int n);
      return {11'(n + 1000), 11'(n)};
   endfunction
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic capture(input logic mode, input logic [7:0] dec, input int trig_n,
                          input logic [3:0] post, output int last);
      int n;
      n = 0;
      last = -1;
      @(negedge clock);
      i_start = 1'b1; i_mode = mode; i_decim = dec; i_post_count = post; i_data = '0;
      @(negedge clock);
      i_start = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (o_state == 2'd3) begin
            last = n - 1;
            break;
         end
         i_data = smp(n);
         i_trigger = (n == trig_n);
         n++;
         @(negedge clock);
      end
      i_trigger = 1'b0;
      if (last < 0) check("capture_timeout", 64'(o_state), 64'd3);
   endtask
   task automatic read_chk(input string name, input logic [3:0] a, input logic [21:0] exp);
      @(negedge clock);
      i_rd_en = 1'b1; i_rd_addr = a;
      @(negedge clock);
      i_rd_en = 1'b0;
      check({name, "_early"}, 64'(o_rd_valid), 64'd0);
      @(negedge clock);
      check({name, "_valid"}, 64'(o_rd_valid), 64'd1);
      check({name, "_data"}, 64'(o_rd_data), 64'(exp));
      @(negedge clock);
      check({name, "_drop"}, 64'(o_rd_valid), 64'd0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
   initial begin
      int last, done_j, bad;
      tbl[0] = '{1'b0, -1, 4'd0, 4'd5, 5, 15, 0};
      tbl[1] = '{1'b0, 3, 4'd0, 4'd15, 15, 15, 0};
      tbl[2] = '{1'b1, 40, 4'd5, 4'd0, 30, 45, 8};
      tbl[3] = '{1'b1, 40, 4'd5, 4'd10, 40, 45, 8};
      tbl[4] = '{1'b1, 40, 4'd5, 4'd15, 45, 45, 8};
      tbl[5] = '{1'b1, 3, 4'd2, 4'd3, 3, 5, 3};
      tbl[6] = '{1'b1, 3, 4'd2, 4'd0, 0, 5, 3};
      tbl[7] = '{1'b1, 20, 4'd0, 4'd0, 5, 20, 4};
      tbl[8] = '{1'b1, 20, 4'd0, 4'd15, 20, 20, 4};
      i_reset = 1'b1; i_start = 0; i_abort = 0; i_mode = 0; i_trigger = 0;
      i_rd_en = 0; i_rd_addr = 0; i_post_count = 0; i_decim = 0; i_data = '0;
      repeat (3) @(negedge clock);
      i_reset = 1'b0;
      @(negedge clock);
      check("reset_outs", {o_rd_data, o_rd_valid, o_state, o_mem_full, o_trig_addr, o_wr_addr}, 64'd0);
      foreach (tbl[i]) begin
         capture(tbl[i].mode, 8'd0, tbl[i].trig_n, tbl[i].post, last);
         check($sformatf("row%0d_last", i), 64'(last), 64'(tbl[i].exp_last));
         check($sformatf("row%0d_full", i), 64'(o_mem_full), 64'd1);
         check($sformatf("row%0d_trig", i), 64'(o_trig_addr), 64'(tbl[i].exp_trig));
         read_chk($sformatf("row%0d_rd", i), tbl[i].rd, smp(tbl[i].exp_s));
      end
      // back-to-back reads, oldest = 5 from last row
      @(negedge clock);
      i_rd_en = 1'b1; i_rd_addr = 4'd0;
      @(negedge clock);
      check("b2b_v0", 64'(o_rd_valid), 64'd0);
      i_rd_addr = 4'd1;
      @(negedge clock);
      i_rd_addr = 4'd2;
      check("b2b_d0", {o_rd_valid, o_rd_data}, {1'b1, smp(5)});
      @(negedge clock);
      i_rd_en = 1'b0;
      check("b2b_d1", {o_rd_valid, o_rd_data}, {1'b1, smp(6)});
      @(negedge clock);
      check("b2b_d2", {o_rd_valid, o_rd_data}, {1'b1, smp(7)});
      @(negedge clock);
      check("b2b_hold", {o_rd_valid, o_rd_data}, {1'b0, smp(7)});
      // abort flushes an in-flight read
      i_rd_en = 1'b1; i_rd_addr = 4'd3;
      @(negedge clock);
      i_rd_en = 1'b0; i_abort = 1'b1;
      @(negedge clock);
      i_abort = 1'b0;
      check("flush_v", {o_rd_valid, o_state}, 3'b000);
      @(negedge clock);
      check("flush_v2", 64'(o_rd_valid), 64'd0);
      // reads in IDLE are ignored
      i_rd_en = 1'b1;
      @(negedge clock);
      i_rd_en = 1'b0;
      @(negedge clock);
      check("idle_rd1", 64'(o_rd_valid), 64'd0);
      @(negedge clock);
      check("idle_rd2", 64'(o_rd_valid), 64'd0);
      // abort in POST
      i_start = 1'b1; i_mode = 1'b1; i_decim = 8'd0; i_post_count = 4'd10;
      @(negedge clock);
      i_start = 1'b0; i_trigger = 1'b1;
      @(negedge clock);
      i_trigger = 1'b0;
      @(negedge clock);
      check("post_state", 64'(o_state), 64'd2);
      i_abort = 1'b1;
      @(negedge clock);
      i_abort = 1'b0;
      check("post_abort", {o_state, o_mem_full}, 3'b000);
      // abort + start together in DONE
      capture(1'b1, 8'd0, 0, 4'd0, last);
      check("as_done", 64'(o_state), 64'd3);
      i_abort = 1'b1; i_start = 1'b1;
      @(negedge clock);
      i_abort = 1'b0; i_start = 1'b0;
      check("as_idle", {o_state, o_mem_full}, 3'b000);
      @(negedge clock);
      check("as_stay", 64'(o_state), 64'd0);
      // decimation 2: pointer advances every 3rd cycle
      i_start = 1'b1; i_mode = 1'b0; i_decim = 8'd2;
      @(negedge clock);
      i_start = 1'b0;
      done_j = -1; bad = 0;
      for (int j = 0; j < 80; j++) begin
         if (o_state == 2'd3) begin
            done_j = j;
            break;
         end
         if (o_wr_addr != 4'(((j + 2) / 3) % 16)) bad++;
         @(negedge clock);
      end
      check("decim_spacing", 64'(bad), 64'd0);
      check("decim_done", 64'(done_j >= 46 && done_j <= 48), 64'd1);
      // async reset mid-ARMED
      i_start = 1'b1; i_decim = 8'd0;
      @(negedge clock);
      i_start = 1'b0;
      repeat (5) @(negedge clock);
      check("pre_rst_wr", {o_state, o_wr_addr}, {2'd1, 4'd5});
      #2 i_reset = 1'b1;
      #1 check("async_rst", {o_rd_data, o_rd_valid, o_state, o_mem_full, o_trig_addr, o_wr_addr}, 64'd0);
      @(negedge clock);
      i_reset = 1'b0;
      capture(1'b0, 8'd0, -1, 4'd0, last);
      check("post_rst_last", 64'(last), 64'd15);
      read_chk("post_rst_rd", 4'd7, smp(7));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/multi_ch_logger.md
MULTI_CH_LOGGER -- requirements
Module: multi_ch_logger

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of logged channels.
REQ-002 SHALL have parameter DATA_W, default 11, bits per channel.
REQ-003 SHALL have parameter N_ADDR, default 10, address width; depth = 2**N_ADDR words of N_CH*DATA_W bits.
REQ-004 SHALL have port clock, input, 1, sole clock; all logic is rising-edge.
REQ-005 SHALL have port i_reset, input, 1, reset: asynchronous, active-high.
REQ-006 SHALL have port i_data, input, N_CH*DATA_W, sample word; channel k at bits [k*DATA_W +: DATA_W].
REQ-007 SHALL have port i_start, input, 1, single-cycle capture start pulse.
REQ-008 SHALL have port i_abort, input, 1, return to IDLE.
REQ-009 SHALL have port i_mode, input, 1: 0 = one-shot fill, 1 = circular with trigger; sampled only on accepted i_start.
REQ-010 SHALL have port i_trigger, input, 1, trigger event (level, sampled each cycle).
REQ-011 SHALL have port i_post_count, input, N_ADDR, post-trigger write count; latched on trigger.
REQ-012 SHALL have port i_decim, input, 8, decimation: one write every i_decim+1 cycles; latched on accepted i_start.
REQ-013 SHALL have port i_rd_en, input, 1, readback request.
REQ-014 SHALL have port i_rd_addr, input, N_ADDR, logical read index; 0 = oldest stored sample.
REQ-015 SHALL have port o_rd_data, output, N_CH*DATA_W, readback word.
REQ-016 SHALL have port o_rd_valid, output, 1, qualifies o_rd_data for one cycle.
REQ-017 SHALL have port o_state, output, 2, FSM state: IDLE=0, ARMED=1, POST=2, DONE=3.
REQ-018 SHALL have port o_mem_full, output, 1, high iff state is DONE.
REQ-019 SHALL have port o_trig_addr, output, N_ADDR, physical write address at trigger cycle.
REQ-020 SHALL have port o_wr_addr, output, N_ADDR, current physical write pointer.

Function
REQ-021 SHALL contain an internal single-port RAM of 2**N_ADDR x N_CH*DATA_W, written and read on clock.
REQ-022 SHALL, in IDLE or DONE, on i_start: go to ARMED; clear wr_addr, decimation counter and wrapped flag; latch i_mode and i_decim. i_start is ignored in ARMED/POST.
REQ-023 SHALL assert the write strobe in ARMED/POST when the decimation counter is 0, then reload it with the latched i_decim; otherwise decrement it. i_decim=0 writes every cycle.
REQ-024 SHALL write i_data at wr_addr on each strobe and increment wr_addr modulo 2**N_ADDR; wrap from 2**N_ADDR-1 to 0 sets the wrapped flag.
REQ-025 SHALL, in mode 0, go ARMED->DONE on the cycle after the write to address 2**N_ADDR-1; ignore i_trigger.
REQ-026 SHALL, in mode 1 ARMED with i_trigger high: latch o_trig_addr = wr_addr and i_post_count. The same-cycle strobe still writes. Next state is POST, or DONE if i_post_count = 0.
REQ-027 SHALL, in POST, decrement the remaining count on each strobe; the cycle after the write that brings it to 0, go to DONE.
REQ-028 SHALL ignore i_trigger in IDLE, POST and DONE.
REQ-029 SHALL compute the oldest pointer at DONE as follows: mode 0 = 0; mode 1 = wr_addr if wrapped, else 0.
REQ-030 SHALL accept i_rd_en only in DONE: physical address = (oldest + i_rd_addr) mod 2**N_ADDR. o_rd_data and o_rd_valid appear exactly 2 cycles later, with registered RAM output.
REQ-031 SHALL hold o_rd_data between valid reads; o_rd_valid is low otherwise, and i_rd_en outside DONE is ignored.
REQ-032 SHALL, on i_abort in any state, go to IDLE next cycle and flush the read pipeline (no o_rd_valid). RAM contents are retained.
REQ-033 SHALL give i_abort priority over i_start and i_trigger in the same cycle.
REQ-034 SHALL let back-to-back i_rd_en produce one valid result per cycle.

Reset
REQ-035 SHALL, while i_reset is high, immediately force: state IDLE, o_rd_data=0, o_rd_valid=0, o_mem_full=0, o_trig_addr=0, o_wr_addr=0, counters and flags 0. RAM contents are unspecified.
REQ-036 SHALL abandon any capture or readback in progress on reset assertion. No write occurs while reset is high.

Verification
REQ-037 SHALL cover: N_ADDR=4, mode 0, decim 0, ramp data 0,1,2.., start -> DONE after 16 writes; rd_addr 5 -> o_rd_data 5 with o_rd_valid two cycles later.
REQ-038 SHALL cover: N_ADDR=4, mode 1, ramp, trigger with sample 40, post 5 -> o_trig_addr 8, DONE after sample 45; rd_addr 0 -> 30, rd_addr 10 -> 40.
REQ-039 SHALL cover: mode 1, trigger with sample 3, post 2 (no wrap) -> o_trig_addr 3, oldest 0, rd_addr 3 -> 3.
REQ-040 SHALL cover: decim 2, mode 0 -> writes on every 3rd cycle; DONE 48 cycles after start.
REQ-041 SHALL cover: abort in POST -> o_state 0 next cycle, o_mem_full 0; abort+start same cycle in DONE -> IDLE.
REQ-042 SHALL cover: i_reset asserted mid-ARMED -> all outputs 0 without waiting for a clock edge; start after release -> normal capture.
